// File: rtl/ws281x_decode.sv
// WS281x single-wire receiver: synchronises the line, slices each high pulse to a bit,
// packs bits MSB-first into bytes and writes them to a frame buffer port.
module ws281x_decode #(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 8,
  parameter int RST_CYCLES = 4000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ws281x_data_in,
  input  logic [CNT_WIDTH-1:0]  thr_cnt_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [7:0]            wr_data_out,
  output logic                  wr_done_out,
  output logic                  err_out
);

  localparam int IDLE_W = $clog2(RST_CYCLES + 1);
  localparam logic [IDLE_W-1:0]     IDLE_END = IDLE_W'(RST_CYCLES);
  localparam logic [CNT_WIDTH-1:0]  HIGH_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t                r_state, w_next;
  logic                  r_sync1, r_sync2, r_prev;
  logic [CNT_WIDTH-1:0]  r_high;
  logic [IDLE_W-1:0]     r_idle;
  logic [6:0]            r_shift;
  logic [2:0]            r_bitcnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_full;     // last address written; further bytes overflow
  logic                  r_ovf;      // overflow already reported this frame
  logic                  r_written;
  logic                  r_wr_en, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;

  logic       w_line, w_rise, w_fall, w_bit;
  logic [7:0] w_byte;
  logic       w_take, w_sat, w_eof;

  assign w_line = r_sync2;
  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_bit  = (r_high >= thr_cnt_in);
  assign w_byte = {r_shift, w_bit};

  // NOTE: every output of this block is given a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_sat  = 1'b0;
    w_eof  = 1'b0;
    case (r_state)
      S_SYNC: if (r_idle == IDLE_END) w_next = S_IDLE;
      S_IDLE: if (w_rise) w_next = S_HIGH;
      S_HIGH: begin
        if (w_fall) begin
          w_take = 1'b1;
          w_next = S_LOW;
        end else if (r_high == HIGH_MAX) begin
          w_sat  = 1'b1;
          w_next = S_SYNC;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_next = S_HIGH;
        end else if (r_idle == IDLE_END) begin
          w_eof  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_SYNC;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_SYNC;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_high    <= '0;
      r_idle    <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_addr    <= '0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_written <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_sync1 <= ws281x_data_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;

      if (w_line)                r_idle <= '0;
      else if (r_idle != IDLE_END) r_idle <= r_idle + 1'b1;

      // The rising-edge cycle is itself the first high cycle of the pulse.
      if (w_rise)                                      r_high <= CNT_WIDTH'(1);
      else if (r_state == S_HIGH && r_high != HIGH_MAX) r_high <= r_high + 1'b1;

      if (w_take) begin
        r_shift  <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          if (!r_full) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_byte;
            r_written <= 1'b1;
            if (r_addr == ADDR_MAX) r_full <= 1'b1;
            else                    r_addr <= r_addr + 1'b1;
          end else if (!r_ovf) begin
            r_err <= 1'b1;
            r_ovf <= 1'b1;
          end
        end
      end

      if (w_sat || w_eof) begin
        r_err     <= w_sat | (r_bitcnt != 3'd0);
        r_done    <= w_eof & r_written;
        r_bitcnt  <= '0;
        r_addr    <= '0;
        r_full    <= 1'b0;
        r_ovf     <= 1'b0;
        r_written <= 1'b0;
      end
    end
  end

  assign wr_en_out   = r_wr_en;
  assign wr_addr_out = r_wr_addr;
  assign wr_data_out = r_wr_data;
  assign wr_done_out = r_done;
  assign err_out     = r_err;

endmodule

// File: tb/tb_ws281x_decode.sv
// Self-checking bench for ws281x_decode: table vectors, hand-built corner frames and
// a randomized frame, all compared against a frame-level model of the decoder.
module tb_ws281x_decode;

  localparam int RST_CYCLES = 4000;
  localparam int FRAME_MAX  = 64;
  localparam int GAP        = RST_CYCLES + 8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ws281x_data_in;
  logic [7:0] thr_cnt_in;
  logic       wr_en_out;
  logic [5:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic       wr_done_out;
  logic       err_out;

  ws281x_decode dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .ws281x_data_in (ws281x_data_in),
    .thr_cnt_in     (thr_cnt_in),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_done_out    (wr_done_out),
    .err_out        (err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] pat;
    int         thr;
    int         hi1;
    int         hi0;
    logic [7:0] exp;
  } vec_t;

  wr_t wq[$];
  int  err_cnt  = 0;
  int  done_cnt = 0;
  int  both_cnt = 0;
  int  total    = 0;
  int  bad      = 0;
  int  hq[$];
  int  lq[$];

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (wr_en_out) wq.push_back('{addr: wr_addr_out, data: wr_data_out});
      if (err_out) err_cnt++;
      if (wr_done_out) done_cnt++;
      if (err_out && wr_done_out) both_cnt++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    ws281x_data_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_bits(input logic [7:0] b, input int n, input int hi1, input int hi0,
                           input int lo1, input int lo0);
    for (int i = n - 1; i >= 0; i--) begin
      hq.push_back(b[i] ? hi1 : hi0);
      lq.push_back(b[i] ? lo1 : lo0);
    end
  endtask

  task automatic send_queue();
    for (int i = 0; i < hq.size(); i++) begin
      ws281x_data_in = 1'b1;
      repeat (hq[i]) @(negedge clk_in);
      ws281x_data_in = 1'b0;
      repeat (lq[i]) @(negedge clk_in);
    end
  endtask

  // Sends the queued bits as one frame, then checks writes and pulses against
  // what the frame rules predict from the pulse widths alone.
  task automatic play_and_check(input string tag, input logic [7:0] thr, output int w0);
    int         e0, d0, b0, nbits, nbytes, nwr, exp_err;
    logic [7:0] acc;
    logic [7:0] bytes[$];
    thr_cnt_in = thr;
    w0 = wq.size();
    e0 = err_cnt;
    d0 = done_cnt;
    b0 = both_cnt;
    send_queue();
    idle(GAP);
    nbits = hq.size();
    acc = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      acc = {acc[6:0], (hq[i] >= int'(thr)) ? 1'b1 : 1'b0};
      if (i % 8 == 7) bytes.push_back(acc);
    end
    nbytes  = bytes.size();
    nwr     = (nbytes > FRAME_MAX) ? FRAME_MAX : nbytes;
    exp_err = ((nbytes > FRAME_MAX) ? 1 : 0) + ((nbits % 8 != 0) ? 1 : 0);
    check({tag, " writes"}, wq.size() - w0, nwr);
    for (int k = 0; k < nwr && w0 + k < wq.size(); k++) begin
      check($sformatf("%s addr[%0d]", tag, k), int'(wq[w0+k].addr), k);
      check($sformatf("%s data[%0d]", tag, k), int'(wq[w0+k].data), int'(bytes[k]));
    end
    check({tag, " err"}, err_cnt - e0, exp_err);
    check({tag, " done"}, done_cnt - d0, (nwr > 0) ? 1 : 0);
    check({tag, " err+done same cycle"}, both_cnt - b0,
          ((nbits % 8 != 0) && nwr > 0) ? 1 : 0);
    hq.delete();
    lq.delete();
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] main_exp[3];
    int         w0, e0, d0, nbits;

    vecs[0] = '{pat: 8'hA5, thr: 40,  hi1: 60,  hi0: 20, exp: 8'hA5};
    vecs[1] = '{pat: 8'h5A, thr: 40,  hi1: 40,  hi0: 39, exp: 8'h5A};
    vecs[2] = '{pat: 8'hF0, thr: 40,  hi1: 39,  hi0: 20, exp: 8'h00};
    vecs[3] = '{pat: 8'h0F, thr: 20,  hi1: 60,  hi0: 20, exp: 8'hFF};
    vecs[4] = '{pat: 8'h3C, thr: 100, hi1: 200, hi0: 99, exp: 8'h3C};
    main_exp[0] = 8'hA5;
    main_exp[1] = 8'h0F;
    main_exp[2] = 8'hFF;

    rst_in = 1'b1;
    ws281x_data_in = 1'b0;
    thr_cnt_in = 8'd40;
    repeat (3) @(negedge clk_in);
    check("reset wr_en", int'(wr_en_out), 0);
    check("reset err", int'(err_out), 0);
    check("reset done", int'(wr_done_out), 0);
    check("reset addr", int'(wr_addr_out), 0);
    check("reset data", int'(wr_data_out), 0);
    rst_in = 1'b0;

    // Bits straight after reset are ignored until a full low period is seen.
    w0 = wq.size(); e0 = err_cnt; d0 = done_cnt;
    push_bits(8'hA5, 8, 60, 20, 20, 60);
    send_queue();
    hq.delete(); lq.delete();
    idle(GAP);
    check("no-sync writes", wq.size() - w0, 0);
    check("no-sync err", err_cnt - e0, 0);
    check("no-sync done", done_cnt - d0, 0);

    // Nominal three-byte frame.
    for (int i = 0; i < 3; i++) push_bits(main_exp[i], 8, 60, 20, 20, 60);
    play_and_check("main", 8'd40, w0);
    for (int i = 0; i < 3 && w0 + i < wq.size(); i++)
      check($sformatf("main const[%0d]", i), int'(wq[w0+i].data), int'(main_exp[i]));

    for (int v = 0; v < 5; v++) begin
      push_bits(vecs[v].pat, 8, vecs[v].hi1, vecs[v].hi0, 20, 20);
      play_and_check($sformatf("vec%0d", v), vecs[v].thr[7:0], w0);
      if (w0 < wq.size())
        check($sformatf("vec%0d const", v), int'(wq[w0].data), int'(vecs[v].exp));
    end

    // Randomized frame: random widths and threshold, possibly a partial final byte.
    nbits = int'($urandom_range(8, 40));
    for (int i = 0; i < nbits; i++) begin
      hq.push_back(int'($urandom_range(1, 150)));
      lq.push_back(int'($urandom_range(1, 60)));
    end
    play_and_check("random", 8'($urandom_range(1, 150)), w0);

    // Twelve bits: one full byte plus a partial one.
    push_bits(8'h3C, 8, 60, 20, 20, 60);
    push_bits(8'h0A, 4, 60, 20, 20, 60);
    play_and_check("partial", 8'd40, w0);

    // 65 bytes with short pulses: the last byte overflows the buffer.
    for (int i = 0; i < FRAME_MAX + 1; i++) push_bits(8'($urandom), 8, 6, 2, 3, 7);
    play_and_check("overflow", 8'd4, w0);

    // Overlong high pulse saturates the counter and forces a resync.
    w0 = wq.size(); e0 = err_cnt; d0 = done_cnt;
    ws281x_data_in = 1'b1;
    repeat (300) @(negedge clk_in);
    idle(GAP);
    check("sat writes", wq.size() - w0, 0);
    check("sat err", err_cnt - e0, 1);
    check("sat done", done_cnt - d0, 0);
    push_bits(8'h96, 8, 60, 20, 20, 60);
    play_and_check("after-sat", 8'd40, w0);

    // Reset in the middle of a byte aborts the frame; later bits need a resync.
    w0 = wq.size(); e0 = err_cnt; d0 = done_cnt;
    thr_cnt_in = 8'd40;
    push_bits(8'hC3, 8, 60, 20, 20, 60);
    push_bits(8'h05, 4, 60, 20, 20, 60);
    send_queue();
    hq.delete(); lq.delete();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("midrst err", int'(err_out), 0);
    rst_in = 1'b0;
    push_bits(8'h81, 8, 60, 20, 20, 60);
    send_queue();
    hq.delete(); lq.delete();
    idle(GAP);
    check("midrst writes", wq.size() - w0, 1);
    if (w0 < wq.size()) check("midrst data", int'(wq[w0].data), 8'hC3);
    check("midrst err", err_cnt - e0, 0);
    check("midrst done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
